// File: rtl/clk_trig_decoder.sv
// Receive-side decoder for the trigger-modulated clock line.
// Measures high/low phase lengths on fastclk and recovers the trigger level.
module clk_trig_decoder #(
   parameter int CNT_W   = 8,
   parameter int MISS_TH = 24,
   parameter int LOCK_N  = 4
) (
   input  logic fastclk,
   input  logic reset,
   input  logic clk_in,
   input  logic mode,
   output logic trig_out,
   output logic trig_valid,
   output logic err,
   output logic locked
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0] TH_PRE   = CNT_W'(MISS_TH - 1);
   localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);
   localparam logic [3:0]       LOCK_PRE = 4'(LOCK_N - 1);

   typedef enum logic [1:0] {
      IDLE,
      MEAS_HIGH,
      MEAS_LOW
   } state_t;

   state_t           state;
   logic             d1, d2, d3;
   logic             mode_q;
   logic [CNT_W-1:0] hi_cnt, lo_cnt;
   logic [3:0]       good_cnt;

   logic rise, fall, mode_chg;
   logic hi_sat, lo_sat;

   assign rise     = d2 & ~d3;
   assign fall     = ~d2 & d3;
   assign mode_chg = mode ^ mode_q;
   assign hi_sat   = (hi_cnt == CNT_MAX);
   assign lo_sat   = (lo_cnt == CNT_MAX);

   always_ff @(posedge fastclk) begin
      if (reset) begin
         d1         <= 1'b0;
         d2         <= 1'b0;
         d3         <= 1'b0;
         mode_q     <= 1'b0;
         state      <= IDLE;
         hi_cnt     <= '0;
         lo_cnt     <= '0;
         good_cnt   <= '0;
         trig_out   <= 1'b0;
         trig_valid <= 1'b0;
         err        <= 1'b0;
         locked     <= 1'b0;
      end else begin
         d1         <= clk_in;
         d2         <= d1;
         d3         <= d2;
         mode_q     <= mode;
         trig_valid <= 1'b0;
         err        <= 1'b0;

         // a mode switch restarts acquisition without flagging an error
         if (mode_chg) begin
            state    <= IDLE;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            trig_out <= 1'b0;
            locked   <= 1'b0;
            good_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     hi_cnt <= CNT_ONE;
                     lo_cnt <= '0;
                     state  <= MEAS_HIGH;
                  end
               end

               MEAS_HIGH: begin
                  if (fall) begin
                     lo_cnt <= CNT_ONE;
                     state  <= MEAS_LOW;
                  end else if (hi_cnt == CNT_PRE) begin
                     hi_cnt   <= CNT_MAX;
                     err      <= 1'b1;
                     good_cnt <= '0;
                     locked   <= 1'b0;
                     state    <= IDLE;
                  end else if (!hi_sat) begin
                     hi_cnt <= hi_cnt + CNT_ONE;
                  end
               end

               MEAS_LOW: begin
                  if (rise) begin
                     hi_cnt <= CNT_ONE;
                     lo_cnt <= '0;
                     state  <= MEAS_HIGH;
                     if (!mode_q) begin
                        trig_out   <= 1'b0;
                        trig_valid <= 1'b1;
                        if (good_cnt != LOCK_MAX)
                           good_cnt <= good_cnt + 4'd1;
                        locked <= (good_cnt >= LOCK_PRE);
                     end else if (hi_sat || lo_sat
                                  || hi_cnt == lo_cnt) begin
                        err      <= 1'b1;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                     end else begin
                        trig_out   <= (lo_cnt > hi_cnt);
                        trig_valid <= 1'b1;
                        if (good_cnt != LOCK_MAX)
                           good_cnt <= good_cnt + 4'd1;
                        locked <= (good_cnt >= LOCK_PRE);
                     end
                  end else if (mode_q && lo_cnt == CNT_PRE) begin
                     lo_cnt   <= CNT_MAX;
                     err      <= 1'b1;
                     good_cnt <= '0;
                     locked   <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     // missing-clock low phase saturates silently
                     if (!lo_sat)
                        lo_cnt <= lo_cnt + CNT_ONE;
                     if (!mode_q && lo_cnt == TH_PRE) begin
                        trig_out   <= 1'b1;
                        trig_valid <= 1'b1;
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_trig_decoder.sv
// Directed bench for clk_trig_decoder.
// Line driven on the falling fastclk edge; outputs sampled there too.
module tb_clk_trig_decoder;

   logic fastclk = 1'b0;
   logic reset;
   logic clk_in;
   logic mode;
   logic trig_out, trig_valid, err, locked;

   int n_chk  = 0;
   int n_pass = 0;

   int ncyc     = 0;
   int nvalid   = 0;
   int nerr     = 0;
   int last_v   = -1;
   int prev_v   = -1;
   int last_e   = -1;
   int lock_at  = -1;
   int n_both   = 0;
   int n_unlock = 0;
   int rise_cyc = 0;
   int fall_cyc = 0;
   logic last_trig = 1'b0;
   logic err_trig  = 1'b0;
   logic err_lock  = 1'b0;
   logic prev_lock = 1'b0;

   int v0, e0, v1, e1, v2, e2, v3, e3, v4;

   clk_trig_decoder #(
      .CNT_W  (5),
      .MISS_TH(24),
      .LOCK_N (4)
   ) dut (
      .fastclk   (fastclk),
      .reset     (reset),
      .clk_in    (clk_in),
      .mode      (mode),
      .trig_out  (trig_out),
      .trig_valid(trig_valid),
      .err       (err),
      .locked    (locked)
   );

   always #5 fastclk = ~fastclk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(negedge fastclk);
      ncyc++;
      if (trig_valid) begin
         nvalid++;
         prev_v    = last_v;
         last_v    = ncyc;
         last_trig = trig_out;
      end
      if (err) begin
         nerr++;
         last_e   = ncyc;
         err_trig = trig_out;
         err_lock = locked;
      end
      if (trig_valid && err) n_both++;
      if (locked && !prev_lock) lock_at = nvalid;
      if (!locked && prev_lock) n_unlock++;
      prev_lock = locked;
   endtask

   task automatic line(input logic lvl, input int n);
      if (lvl && !clk_in) rise_cyc = ncyc;
      if (!lvl && clk_in) fall_cyc = ncyc;
      clk_in = lvl;
      repeat (n) step();
   endtask

   task automatic period(input int h, input int l);
      line(1'b1, h);
      line(1'b0, l);
   endtask

   initial begin
      reset  = 1'b1;
      mode   = 1'b1;
      clk_in = 1'b0;
      repeat (3) step();
      check("rst_trig", trig_out, 0);
      check("rst_valid", trig_valid, 0);
      check("rst_err", err, 0);
      check("rst_lock", locked, 0);
      reset = 1'b0;
      repeat (3) step();
      check("post_rst_err", nerr, 0);

      // duty-cycle, trigger 0
      v0 = nvalid;
      repeat (6) period(12, 4);
      check("d0_count", nvalid - v0, 5);
      check("d0_trig", last_trig, 0);
      check("d0_spacing", last_v - prev_v, 16);
      check("d0_latency", last_v - rise_cyc, 3);
      check("d0_lock_at", lock_at, 4);
      check("d0_locked", locked, 1);

      // duty-cycle, trigger 1
      period(4, 12);
      line(1'b1, 4);
      check("d1_latency", last_v - rise_cyc, 3);
      check("d1_trig", last_trig, 1);
      line(1'b0, 12);
      repeat (2) period(4, 12);
      check("d1_locked", locked, 1);
      check("d1_no_unlock", n_unlock, 0);

      // equal phases
      e0 = nerr;
      period(8, 8);
      line(1'b1, 4);
      check("eq_err_time", last_e - rise_cyc, 3);
      check("eq_err_cnt", nerr - e0, 1);
      check("eq_trig_hold", err_trig, 1);
      check("eq_lock_drop", err_lock, 0);
      v1 = nvalid;
      line(1'b0, 12);
      repeat (4) period(4, 12);
      check("eq_relock", lock_at - v1, 4);
      check("eq_locked", locked, 1);

      // missing clock
      mode = 1'b0;
      step();
      check("mc_trig_clr", trig_out, 0);
      check("mc_lock_clr", locked, 0);
      e1 = nerr;
      repeat (3) period(8, 8);
      line(1'b1, 8);
      line(1'b0, 40);
      check("miss_th_time", last_v - fall_cyc, 26);
      check("miss_th_trig", last_trig, 1);
      line(1'b1, 8);
      check("miss_rise_time", last_v - rise_cyc, 3);
      check("miss_rise_trig", last_trig, 0);
      check("miss_no_err", nerr - e1, 0);
      line(1'b0, 4);

      // stuck line
      mode = 1'b1;
      step();
      e2 = nerr;
      v2 = nvalid;
      line(1'b0, 2);
      line(1'b1, 40);
      check("stuck_err_time", last_e - rise_cyc, 33);
      check("stuck_err_cnt", nerr - e2, 1);
      line(1'b0, 4);
      period(12, 4);
      check("stuck_no_valid", nvalid - v2, 0);
      line(1'b1, 12);
      check("stuck_first_v", last_v - rise_cyc, 3);
      check("stuck_first_t", last_trig, 0);
      line(1'b0, 4);

      // reset mid low phase
      repeat (2) period(4, 12);
      line(1'b1, 4);
      line(1'b0, 5);
      check("pre_rst_trig", trig_out, 1);
      reset = 1'b1;
      step();
      step();
      check("mrst_trig", trig_out, 0);
      check("mrst_valid", trig_valid, 0);
      check("mrst_lock", locked, 0);
      reset = 1'b0;
      e3 = nerr;
      v3 = nvalid;
      line(1'b0, 5);
      line(1'b1, 4);
      line(1'b0, 12);
      check("mrst_no_valid", nvalid - v3, 0);
      line(1'b1, 4);
      check("mrst_first_v", last_v - rise_cyc, 3);
      check("mrst_first_t", last_trig, 1);
      line(1'b0, 12);

      // mode toggled mid high phase
      line(1'b1, 2);
      mode = 1'b0;
      step();
      check("tog_trig", trig_out, 0);
      mode = 1'b1;
      v4 = nvalid;
      line(1'b1, 2);
      line(1'b0, 12);
      period(4, 12);
      check("tog_no_valid", nvalid - v4, 0);
      line(1'b1, 4);
      check("tog_first_v", last_v - rise_cyc, 3);
      check("tog_first_t", last_trig, 1);
      line(1'b0, 4);
      check("rst_mode_no_err", nerr - e3, 0);
      check("valid_err_excl", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_trig_decoder.md
# clk_trig_decoder

- Receive-side decoder for the trigger-modulated clock line.
- Oversamples the incoming clock line on `fastclk` and measures the high and low phase lengths of each period.
- Recovers the trigger level in either of the two encodings the team generates:
  - duty-cycle (75% high = trigger 0, 25% high = trigger 1);
  - missing-clock (line held low = trigger 1).
- Sits at the far end of the SMA clock cable, ahead of the trigger consumer logic.

## Interface

Parameters:
- `CNT_W`, 8: width of the phase counters; counters saturate at 2^CNT_W−1.
- `MISS_TH`, 24: missing-clock mode low-phase length (`fastclk` cycles) at which trigger 1 is declared; 2 ≤ MISS_TH < 2^CNT_W−1.
- `LOCK_N`, 4: consecutive error-free periods required to assert `locked`; 1..15.

Ports:
- `fastclk` in 1: sampling clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `clk_in` in 1: modulated clock line, asynchronous to `fastclk`.
- `mode` in 1: 0 = missing-clock decoding, 1 = duty-cycle decoding; quasi-static.
- `trig_out` out 1: recovered trigger level.
- `trig_valid` out 1: one-cycle pulse each time a trigger decision is made.
- `err` out 1: one-cycle pulse on an undecodable period.
- `locked` out 1: high after `LOCK_N` consecutive good periods.

## Operation

**Reset and input path**
- Reset values: all outputs 0, state IDLE, both counters 0, sync flops 0, good-period count 0.
- `clk_in` passes through a 2-flop synchronizer (d1, d2) plus a history flop d3.
- `rise` = d2 & ~d3; `fall` = ~d2 & d3; each is a one-cycle strobe.

**States**
- IDLE: ignore everything until `rise`.
  - On `rise`: `hi_cnt` ← 1, `lo_cnt` ← 0, go to MEAS_HIGH. No decision is made.
- MEAS_HIGH: `hi_cnt` increments (saturating) each cycle without `fall`.
  - On `fall`: `lo_cnt` ← 1, go to MEAS_LOW.
- MEAS_LOW: `lo_cnt` increments (saturating) each cycle without `rise`.
  - On `rise`: evaluate the period, then `hi_cnt` ← 1, `lo_cnt` ← 0, go to MEAS_HIGH.

**Evaluation, duty-cycle mode (`mode`=1)**
- Either counter saturated: `err` pulse, `trig_out` holds.
- `hi_cnt` > `lo_cnt`: `trig_out` ← 0, `trig_valid` pulse.
- `lo_cnt` > `hi_cnt`: `trig_out` ← 1, `trig_valid` pulse.
- Equal: `err` pulse, `trig_out` holds.
- Stuck line: if a counter reaches saturation in either MEAS state, `err` pulses once and the state returns to IDLE.

**Missing-clock mode (`mode`=0)**
- In MEAS_LOW, on the edge where `lo_cnt` becomes `MISS_TH`: `trig_out` ← 1, `trig_valid` pulse.
  - Fires once per low phase.
  - `lo_cnt` keeps counting and saturates silently; in this mode, low-phase saturation is neither an error nor a return to IDLE.
- On every `rise` out of MEAS_LOW: `trig_out` ← 0, `trig_valid` pulse.
- `hi_cnt` saturation: `err` pulse, return to IDLE.

**Lock**
- A good period is a MEAS_LOW→MEAS_HIGH evaluation without `err`; each one increments the good-period count (saturating at `LOCK_N`).
- `locked` = 1 when the count equals `LOCK_N`.
- Any `err` clears the count and `locked` on the same edge that `err` asserts.
- A missing-clock trigger phase counts as one good period at its closing `rise`.

**Mode change**
- `mode` is registered internally.
- A change detected on any edge sends the state to IDLE and clears the counters, `trig_out`, `locked` and the good-period count. No `err` is raised.

**Simultaneous events**
- Reset dominates everything.
- A mode change dominates a `rise` or `fall` in the same cycle.
- If the threshold and `rise` coincide, the `rise` takes effect: `trig_out` ← 0 and a single `trig_valid` pulse.

## Timing

- `clk_in` edge first sampled at `fastclk` edge k → d2 at k+1 → strobe during cycle k+1..k+2.
- `trig_out`, `trig_valid`, `err` and `locked` are registered and update at edge k+2: 3-edge latency from line edge to decision.
- Phase counts equal the synchronized phase length in `fastclk` cycles; ±1 cycle of jitter is inherent in the asynchronous sampling.
- Reset is sampled only on a `fastclk` edge. Reset asserted mid-period discards the partial measurement; the first decision after release needs a full rise→fall→rise sequence.
- `trig_valid` and `err` are never high in the same cycle.

## Test plan

- **Duty-cycle, trigger 0:** `mode`=1, line 12 high / 4 low, 6 periods.
  - `trig_valid` every 16 cycles with `trig_out`=0.
  - `locked` rises at the 4th decision.
- **Duty-cycle, trigger 1:** `mode`=1, switch to 4 high / 12 low.
  - First decision after the switch gives `trig_out`=1, 3 edges after the closing rise.
  - `locked` stays 1.
- **Duty-cycle, equal phases:** `mode`=1, one period of 8 high / 8 low inserted.
  - `err` pulse, `trig_out` unchanged, `locked` drops.
  - `locked` returns 4 good periods later.
- **Missing clock:** `mode`=0, `MISS_TH`=24, 8/8 clocking then line held low 40 cycles.
  - `trig_out`=1 with `trig_valid` when `lo_cnt` reaches 24.
  - At the next rise: `trig_out`=0 with `trig_valid`.
- **Stuck line:** `mode`=1, `CNT_W`=5, line held high 40 cycles.
  - One `err` pulse at saturation (31), state IDLE.
  - No `trig_valid` until a full period is seen.
- **Reset and mode change:** `reset` mid-MEAS_LOW, then `mode` toggled mid-period.
  - Outputs 0 after each.
  - No `err`.
  - First `trig_valid` only after a complete period.
